// File: rtl/shift_register_n.sv
// rtl/shift_register_n.sv - WIDTH-bit register with load/shift/rotate ops and a counted multi-cycle shift sequence.
module shift_register_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerInL,
  input  logic             SerInR,
  input  logic             Start,
  input  logic [CNT_W-1:0] Amount,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] notQ,
  output logic             SerOutL,
  output logic             SerOutR,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic {Idle, Shifting} stateT;

  localparam logic [2:0] ModeHold   = 3'b000;
  localparam logic [2:0] ModeLoad   = 3'b001;
  localparam logic [2:0] ModeShl    = 3'b010;
  localparam logic [2:0] ModeShr    = 3'b011;
  localparam logic [2:0] ModeRol    = 3'b100;
  localparam logic [2:0] ModeRor    = 3'b101;
  localparam logic [2:0] ModeAsr    = 3'b110;
  localparam logic [2:0] ModeClear  = 3'b111;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  stateT            state, stateNext;
  logic [WIDTH-1:0] qReg, qNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [2:0]       modeReg, modeNext;
  logic             doneReg, doneNext;
  logic             seqMode;

  function automatic logic [WIDTH-1:0] applyMode(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] load,
    input logic             inL,
    input logic             inR
  );
    logic [WIDTH-1:0] res;
    case (op)
      ModeHold:  res = cur;
      ModeLoad:  res = load;
      ModeShl:   res = {cur[WIDTH-2:0], inR};
      ModeShr:   res = {inL, cur[WIDTH-1:1]};
      ModeRol:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      ModeRor:   res = {cur[0], cur[WIDTH-1:1]};
      ModeAsr:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      ModeClear: res = '0;
      default:   res = cur;
    endcase
    return res;
  endfunction

  // Only the shift/rotate family can be repeated; load, hold and clear ignore Start.
  assign seqMode = (Mode != ModeHold) && (Mode != ModeLoad) && (Mode != ModeClear);

  always_comb begin
    stateNext = state;
    qNext     = qReg;
    cntNext   = cntReg;
    modeNext  = modeReg;
    doneNext  = 1'b0;
    if (En) begin
      case (state)
        Idle: begin
          if (Start && seqMode) begin
            if (Amount == '0) begin
              doneNext = 1'b1;
            end else begin
              modeNext  = Mode;
              cntNext   = Amount;
              stateNext = Shifting;
            end
          end else begin
            qNext = applyMode(Mode, qReg, D, SerInL, SerInR);
          end
        end
        Shifting: begin
          qNext   = applyMode(modeReg, qReg, D, SerInL, SerInR);
          cntNext = cntReg - CntOne;
          if (cntReg == CntOne) begin
            stateNext = Idle;
            doneNext  = 1'b1;
          end
        end
        default: stateNext = Idle;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= Idle;
      qReg    <= '0;
      cntReg  <= '0;
      modeReg <= ModeHold;
      doneReg <= 1'b0;
    end else begin
      state   <= stateNext;
      qReg    <= qNext;
      cntReg  <= cntNext;
      modeReg <= modeNext;
      doneReg <= doneNext;
    end
  end

  assign Q       = qReg;
  assign notQ    = ~qReg;
  assign SerOutL = qReg[WIDTH-1];
  assign SerOutR = qReg[0];
  assign Busy    = (state == Shifting);
  assign Done    = doneReg;

endmodule

// File: tb/tb_shift_register_n.sv
// tb/tb_shift_register_n.sv - scoreboard bench for shift_register_n (WIDTH=8, CNT_W=4).
module tb_shift_register_n;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       En = 1'b0;
  logic [2:0] Mode = 3'b000;
  logic [7:0] D = 8'h00;
  logic       SerInL = 1'b0;
  logic       SerInR = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Amount = 4'd0;
  logic [7:0] Q, notQ;
  logic       SerOutL, SerOutR, Busy, Done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic       start;
    logic [3:0] amt;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } rowT;

  rowT sb[$];

  shift_register_n #(.WIDTH(8), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .D(D),
    .SerInL(SerInL), .SerInR(SerInR), .Start(Start), .Amount(Amount),
    .Q(Q), .notQ(notQ), .SerOutL(SerOutL), .SerOutR(SerOutR),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  function automatic rowT mk(input logic rst, input logic en, input logic [2:0] mode,
                             input logic [7:0] d, input logic sl, input logic sr,
                             input logic start, input logic [3:0] amt,
                             input logic [7:0] q, input logic busy, input logic done);
    rowT r;
    r.rst = rst; r.en = en; r.mode = mode; r.d = d; r.sl = sl; r.sr = sr;
    r.start = start; r.amt = amt; r.q = q; r.busy = busy; r.done = done;
    return r;
  endfunction

  task automatic drive(input rowT r);
    Rst = r.rst; En = r.en; Mode = r.mode; D = r.d; SerInL = r.sl; SerInR = r.sr;
    Start = r.start; Amount = r.amt;
    sb.push_back(r);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    rowT rows[$];
    rowT e;
    rows.push_back(mk(1, 1, 3'b001, 8'hFF, 0, 0, 1, 4'd3, 8'h00, 0, 0));
    rows.push_back(mk(0, 1, 3'b001, 8'hA5, 0, 0, 0, 4'd0, 8'hA5, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if (Q !== e.q || notQ !== ~e.q || Busy !== e.busy || Done !== e.done) begin
        errors++;
        $display("FAIL reset[%0d]: Q=%h notQ=%h Busy=%b Done=%b, want Q=%h notQ=%h Busy=%b Done=%b",
                 i, Q, notQ, Busy, Done, e.q, ~e.q, e.busy, e.done);
      end
    end
    checks++;
    if (SerOutL !== 1'b1 || SerOutR !== 1'b1) begin
      errors++;
      $display("FAIL reset_serout: SerOutL=%b SerOutR=%b, want 1 1", SerOutL, SerOutR);
    end
  endtask

  task automatic test_single_ops;
    rowT rows[$];
    rowT e;
    rows.push_back(mk(0, 1, 3'b010, 8'h00, 1, 0, 0, 4'd0, 8'h4A, 0, 0));
    rows.push_back(mk(0, 1, 3'b101, 8'h00, 0, 0, 0, 4'd0, 8'h25, 0, 0));
    rows.push_back(mk(0, 1, 3'b001, 8'h80, 0, 0, 0, 4'd0, 8'h80, 0, 0));
    rows.push_back(mk(0, 1, 3'b110, 8'h00, 0, 0, 0, 4'd0, 8'hC0, 0, 0));
    rows.push_back(mk(0, 1, 3'b111, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0));
    rows.push_back(mk(0, 1, 3'b011, 8'h00, 1, 0, 0, 4'd0, 8'h80, 0, 0));
    rows.push_back(mk(0, 1, 3'b100, 8'h00, 0, 0, 0, 4'd0, 8'h01, 0, 0));
    rows.push_back(mk(0, 1, 3'b010, 8'h00, 0, 1, 0, 4'd0, 8'h03, 0, 0));
    rows.push_back(mk(0, 0, 3'b001, 8'hEE, 0, 0, 0, 4'd0, 8'h03, 0, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'hEE, 0, 0, 0, 4'd0, 8'h03, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if (Q !== e.q || notQ !== ~e.q || Busy !== e.busy || Done !== e.done) begin
        errors++;
        $display("FAIL single_ops[%0d]: Q=%h notQ=%h Busy=%b Done=%b, want Q=%h notQ=%h Busy=%b Done=%b",
                 i, Q, notQ, Busy, Done, e.q, ~e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_sequence;
    rowT rows[$];
    rowT e;
    rows.push_back(mk(0, 1, 3'b001, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0));
    rows.push_back(mk(0, 1, 3'b100, 8'h00, 0, 0, 1, 4'd3, 8'h81, 1, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h03, 1, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h06, 1, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h0C, 0, 1));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h0C, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if (Q !== e.q || notQ !== ~e.q || Busy !== e.busy || Done !== e.done) begin
        errors++;
        $display("FAIL sequence[%0d]: Q=%h notQ=%h Busy=%b Done=%b, want Q=%h notQ=%h Busy=%b Done=%b",
                 i, Q, notQ, Busy, Done, e.q, ~e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_en_stall;
    rowT rows[$];
    rowT e;
    rows.push_back(mk(0, 1, 3'b001, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0));
    rows.push_back(mk(0, 1, 3'b100, 8'h00, 0, 0, 1, 4'd3, 8'h81, 1, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h03, 1, 0));
    rows.push_back(mk(0, 0, 3'b001, 8'hFF, 0, 0, 1, 4'd0, 8'h03, 1, 0));
    rows.push_back(mk(0, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h03, 1, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h06, 1, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h0C, 0, 1));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h0C, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if (Q !== e.q || notQ !== ~e.q || Busy !== e.busy || Done !== e.done) begin
        errors++;
        $display("FAIL en_stall[%0d]: Q=%h notQ=%h Busy=%b Done=%b, want Q=%h notQ=%h Busy=%b Done=%b",
                 i, Q, notQ, Busy, Done, e.q, ~e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_boundaries;
    rowT rows[$];
    rowT e;
    logic [7:0] m;
    rows.push_back(mk(0, 1, 3'b001, 8'h3C, 0, 0, 0, 4'd0, 8'h3C, 0, 0));
    rows.push_back(mk(0, 1, 3'b010, 8'h00, 0, 1, 1, 4'd0, 8'h3C, 0, 1));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h3C, 0, 0));
    rows.push_back(mk(0, 1, 3'b001, 8'h5A, 0, 0, 1, 4'd5, 8'h5A, 0, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h5A, 0, 0));
    rows.push_back(mk(0, 1, 3'b011, 8'h00, 0, 0, 1, 4'd2, 8'h5A, 1, 0));
    rows.push_back(mk(0, 1, 3'b001, 8'hFF, 0, 0, 1, 4'd9, 8'h2D, 1, 0));
    rows.push_back(mk(0, 1, 3'b111, 8'hFF, 0, 0, 0, 4'd0, 8'h16, 0, 1));
    // Amount beyond WIDTH: arithmetic right shift saturates to all-MSB.
    rows.push_back(mk(0, 1, 3'b001, 8'h80, 0, 0, 0, 4'd0, 8'h80, 0, 0));
    rows.push_back(mk(0, 1, 3'b110, 8'h00, 0, 0, 1, 4'd10, 8'h80, 1, 0));
    m = 8'h80;
    for (int k = 1; k <= 10; k++) begin
      m = {m[7], m[7:1]};
      rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, m, (k < 10), (k == 10)));
    end
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if (Q !== e.q || notQ !== ~e.q || Busy !== e.busy || Done !== e.done) begin
        errors++;
        $display("FAIL boundaries[%0d]: Q=%h notQ=%h Busy=%b Done=%b, want Q=%h notQ=%h Busy=%b Done=%b",
                 i, Q, notQ, Busy, Done, e.q, ~e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_abort_back_to_back;
    rowT rows[$];
    rowT e;
    rows.push_back(mk(0, 1, 3'b001, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0));
    rows.push_back(mk(0, 1, 3'b100, 8'h00, 0, 0, 1, 4'd3, 8'h81, 1, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h03, 1, 0));
    rows.push_back(mk(1, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0));
    rows.push_back(mk(0, 1, 3'b100, 8'h00, 0, 0, 1, 4'd1, 8'h00, 1, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 1));
    rows.push_back(mk(0, 1, 3'b011, 8'h00, 1, 0, 1, 4'd2, 8'h00, 1, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'h80, 1, 0));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'hC0, 0, 1));
    rows.push_back(mk(0, 1, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'hC0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      checks++;
      if (Q !== e.q || notQ !== ~e.q || Busy !== e.busy || Done !== e.done) begin
        errors++;
        $display("FAIL abort_b2b[%0d]: Q=%h notQ=%h Busy=%b Done=%b, want Q=%h notQ=%h Busy=%b Done=%b",
                 i, Q, notQ, Busy, Done, e.q, ~e.q, e.busy, e.done);
      end
    end
    checks++;
    if (SerOutL !== 1'b1 || SerOutR !== 1'b0) begin
      errors++;
      $display("FAIL abort_b2b_serout: SerOutL=%b SerOutR=%b, want 1 0", SerOutL, SerOutR);
    end
  endtask

  initial begin
    test_reset;
    test_single_ops;
    test_sequence;
    test_en_stall;
    test_boundaries;
    test_abort_back_to_back;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
